// File: rtl/design5_sle_pkg.sv
// Shared constants and the next-state priority function for the SLE storage cell.
package design5_sle_pkg;

   localparam logic MODE_FF         = 1'b0;
   localparam logic MODE_LATCH      = 1'b1;
   localparam logic RST_VAL_DEFAULT = 1'b0;

   // Strict priority: reset, inverted load, hold, synchronous load, data.
   function automatic logic sle_next(
      input logic rst,
      input logic rst_val,
      input logic aln,
      input logic adn,
      input logic en,
      input logic hold,
      input logic sln,
      input logic sd,
      input logic d
   );
      logic nxt;
      if (rst) begin
         nxt = rst_val;
      end else if (!aln) begin
         nxt = ~adn;
      end else if (!en) begin
         nxt = hold;
      end else if (!sln) begin
         nxt = sd;
      end else begin
         nxt = d;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/design5_sle_bit.sv
// Single-bit SLE: priority mux feeding an edge flip-flop and a high-transparent
// latch, with LAT choosing which one drives Q.
module sle_bit
   import design5_sle_pkg::*;
#(
   parameter logic RST_VAL = RST_VAL_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   input  logic en,
   input  logic aln,
   input  logic adn,
   input  logic sln,
   input  logic sd,
   input  logic lat,
   output logic q
);

   logic q_s;
   logic ff_q_r;
   logic lat_q_r;
   logic ff_nxt_s;
   logic lat_nxt_s;
   logic lat_load_s;
   logic lat_en_s;
   logic lat_d_s;

   // Next-value selection for both storage paths.
   always_comb begin
      ff_nxt_s   = sle_next(rst, RST_VAL, aln, adn, en, q_s, sln, sd, d);
      // The latch closes instead of feeding back on hold, avoiding a loop.
      lat_nxt_s  = sle_next(rst, RST_VAL, aln, adn, en, 1'b0, sln, sd, d);
      lat_load_s = rst | ~aln | en;
   end

   // Latch enable/data: in FF mode the latch shadows the flop so a mode switch is seamless.
   always_comb begin
      lat_en_s = 1'b1;
      lat_d_s  = ff_q_r;
      if (lat == MODE_LATCH) begin
         lat_en_s = clk & lat_load_s;
         lat_d_s  = lat_nxt_s;
      end else begin
         lat_en_s = 1'b1;
         lat_d_s  = ff_q_r;
      end
   end

   // Edge-triggered storage path.
   always_ff @(posedge clk) begin
      ff_q_r <= ff_nxt_s;
   end

   // Level-sensitive storage path, transparent while enabled.
   always_latch begin
      if (lat_en_s) begin
         lat_q_r <= lat_d_s;
      end
   end

   // Output select on the current mode.
   always_comb begin
      if (lat == MODE_LATCH) begin
         q_s = lat_q_r;
      end else begin
         q_s = ff_q_r;
      end
   end

   assign q = q_s;

endmodule

// File: rtl/design5_sle.sv
// WIDTH-bit bank of SLE cells sharing clock, reset and control inputs.
module design5_sle
   import design5_sle_pkg::*;
#(
   parameter int unsigned           WIDTH   = 1,
   parameter logic [WIDTH-1:0]      RST_VAL = {WIDTH{RST_VAL_DEFAULT}}
) (
   input  logic [WIDTH-1:0] D,
   input  logic             CLK,
   input  logic             EN,
   input  logic             ALn,
   input  logic [WIDTH-1:0] ADn,
   input  logic             SLn,
   input  logic [WIDTH-1:0] SD,
   input  logic             LAT,
   output logic [WIDTH-1:0] Q,
   input  logic             RST
);

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      sle_bit #(
         .RST_VAL (RST_VAL[i])
      ) u_bit (
         .clk (CLK),
         .rst (RST),
         .d   (D[i]),
         .en  (EN),
         .aln (ALn),
         .adn (ADn[i]),
         .sln (SLn),
         .sd  (SD[i]),
         .lat (LAT),
         .q   (Q[i])
      );
   end

endmodule

// File: tb/tb_design5_sle.sv
// Directed bench for design5_sle: a 1-bit and a 4-bit bank driven by shared controls.
module tb_design5_sle;

   logic       clk;
   logic       rst;
   logic       en;
   logic       aln;
   logic       sln;
   logic       lat;
   logic [0:0] d1, adn1, sd1, q1;
   logic [3:0] d4, adn4, sd4, q4;

   int n_vec = 0;
   int n_err = 0;

   design5_sle #(.WIDTH(1)) dut1 (
      .D(d1), .CLK(clk), .EN(en), .ALn(aln), .ADn(adn1), .SLn(sln),
      .SD(sd1), .LAT(lat), .Q(q1), .RST(rst)
   );

   design5_sle #(.WIDTH(4), .RST_VAL(4'h6)) dut4 (
      .D(d4), .CLK(clk), .EN(en), .ALn(aln), .ADn(adn4), .SLn(sln),
      .SD(sd4), .LAT(lat), .Q(q4), .RST(rst)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic edge1();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; aln = 1'b1; sln = 1'b1; lat = 1'b0;
      d1 = 1'b0; adn1 = 1'b1; sd1 = 1'b0;
      d4 = 4'h0; adn4 = 4'hF; sd4 = 4'h0;
      edge1();
      chk("rst_q1", {3'b000, q1}, 4'h0);
      chk("rst_q4", q4, 4'h6);

      // Hold with EN=0 over three edges
      rst = 1'b0; d1 = 1'b1; d4 = 4'hF;
      for (int i = 0; i < 3; i++) begin
         edge1();
         chk("hold_q1", {3'b000, q1}, 4'h0);
      end
      chk("hold_q4", q4, 4'h6);

      // Synchronous load via SLn, then plain D
      en = 1'b1; sln = 1'b0; sd1 = 1'b1; sd4 = 4'h5;
      #1;
      chk("sl_before_edge", {3'b000, q1}, 4'h0);
      edge1();
      chk("sl1_q1", {3'b000, q1}, 4'h1);
      chk("sl1_q4", q4, 4'h5);
      sd1 = 1'b0; sd4 = 4'hA;
      edge1();
      chk("sl0_q1", {3'b000, q1}, 4'h0);
      chk("sl0_q4", q4, 4'hA);
      sln = 1'b1; d1 = 1'b1; d4 = 4'hA;
      edge1();
      chk("d1_q1", {3'b000, q1}, 4'h1);
      chk("d1_q4", q4, 4'hA);
      d1 = 1'b0; d4 = 4'h3;
      edge1();
      chk("d0_q1", {3'b000, q1}, 4'h0);
      chk("d0_q4", q4, 4'h3);

      // ALn load with EN=0, not acting between edges
      en = 1'b0; aln = 1'b0; adn1 = 1'b0; adn4 = 4'h9;
      #1;
      chk("aln_between_edges", {3'b000, q1}, 4'h0);
      edge1();
      chk("aln_adn0_q1", {3'b000, q1}, 4'h1);
      chk("aln_q4", q4, 4'h6);
      adn1 = 1'b1; adn4 = 4'h0;
      edge1();
      chk("aln_adn1_q1", {3'b000, q1}, 4'h0);
      chk("aln_q4_all1", q4, 4'hF);

      // Priority: RST over ALn, then ALn over SLn
      rst = 1'b1; adn1 = 1'b0; adn4 = 4'h0;
      edge1();
      chk("rst_beats_aln_q1", {3'b000, q1}, 4'h0);
      chk("rst_beats_aln_q4", q4, 4'h6);
      rst = 1'b0; adn1 = 1'b1; adn4 = 4'h3; en = 1'b1; sln = 1'b0; sd1 = 1'b1; sd4 = 4'hF;
      edge1();
      chk("aln_beats_sl_q1", {3'b000, q1}, 4'h0);
      chk("aln_beats_sl_q4", q4, 4'hC);
      aln = 1'b1;
      edge1();
      chk("sl_after_aln_q1", {3'b000, q1}, 4'h1);
      chk("sl_after_aln_q4", q4, 4'hF);

      // Latch mode, within the current CLK-high phase
      lat = 1'b1; sln = 1'b1; d1 = 1'b0; d4 = 4'h2;
      #1;
      chk("lat_transp_q1", {3'b000, q1}, 4'h0);
      chk("lat_transp_q4", q4, 4'h2);
      d1 = 1'b1; d4 = 4'h7;
      #1;
      chk("lat_follow_q1", {3'b000, q1}, 4'h1);
      chk("lat_follow_q4", q4, 4'h7);
      @(negedge clk);
      #1;
      d1 = 1'b0; d4 = 4'h1;
      #1;
      chk("lat_low_hold_q1", {3'b000, q1}, 4'h1);
      chk("lat_low_hold_q4", q4, 4'h7);
      edge1();
      chk("lat_rise_q1", {3'b000, q1}, 4'h0);
      chk("lat_rise_q4", q4, 4'h1);
      rst = 1'b1;
      #1;
      chk("lat_rst_q4", q4, 4'h6);
      rst = 1'b0;
      #1;
      chk("lat_rst_rel_q4", q4, 4'h1);
      en = 1'b0; d4 = 4'h9;
      #1;
      chk("lat_en0_hold_q4", q4, 4'h1);

      // Back to flip-flop mode during CLK low
      @(negedge clk);
      #1;
      lat = 1'b0; en = 1'b1; d1 = 1'b1; d4 = 4'hB;
      #1;
      chk("ff_back_no_transp_q4", q4, 4'h1);
      edge1();
      chk("ff_back_edge_q1", {3'b000, q1}, 4'h1);
      chk("ff_back_edge_q4", q4, 4'hB);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
